// File: rtl/comb_bool_kmap1_if.sv
// Signal bundle for the three-input OR K-map block: a/b/c in, f out.
// Handshake: none; f is a pure combinational response to a/b/c, valid whenever inputs are stable.
interface comb_bool_kmap1_if;
  logic a;
  logic b;
  logic c;
  logic f;

  modport master (
    output a,
    output b,
    output c,
    input  f
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output f
  );
endinterface

// File: rtl/comb_bool_kmap1.sv
// Three-input K-map with a single 0 at minterm 000, so f = a | b | c.
// Purely combinational; clk and reset are accepted on the port list but never reach f.
module comb_bool_kmap1 (
  input logic             clk,
  input logic             reset,
  comb_bool_kmap1_if.slave bus
);

  logic [2:0] idx;
  logic       f_comb;

  assign idx = {bus.a, bus.b, bus.c};

  // Full case with a default so no latch can be inferred.
  always_comb begin
    f_comb = 1'b1;
    case (idx)
      3'b000:  f_comb = 1'b0;
      default: f_comb = 1'b1;
    endcase
  end

  assign bus.f = f_comb;

  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset};

endmodule

// File: tb/tb_comb_bool_kmap1.sv
// Directed bench for comb_bool_kmap1: sweep, walk, reset independence, history independence.
module tb_comb_bool_kmap1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  comb_bool_kmap1_if bus ();

  comb_bool_kmap1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive inputs 1 unit after a rising edge, then sample 8 units later.
  task automatic apply(input logic [2:0] abc);
    @(posedge clk);
    #1;
    bus.a = abc[2];
    bus.b = abc[1];
    bus.c = abc[0];
    #8;
  endtask

  task automatic apply_check(input string tag, input logic [2:0] abc, input logic exp);
    apply(abc);
    check(tag, bus.f, exp);
  endtask

  logic       sweep_exp [8];
  logic [2:0] hist_pat  [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.a = 1'b0;
    bus.b = 1'b0;
    bus.c = 1'b0;
    sweep_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    hist_pat  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

    // f during reset with 000 applied
    #3;
    check("reset_000", bus.f, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // exhaustive sweep
    for (int i = 0; i < 8; i++)
      apply_check($sformatf("sweep_%0d", i), 3'(i), sweep_exp[i]);

    // single-input walk from 000
    apply_check("walk_zero", 3'b000, 1'b0);
    apply_check("walk_c",    3'b001, 1'b1);
    apply_check("walk_zero", 3'b000, 1'b0);
    apply_check("walk_b",    3'b010, 1'b1);
    apply_check("walk_zero", 3'b000, 1'b0);
    apply_check("walk_a",    3'b100, 1'b1);

    // return to zero in the same cycle
    apply_check("rtz_111", 3'b111, 1'b1);
    apply_check("rtz_000", 3'b000, 1'b0);

    // reset held high
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply_check("rst_hold_000", 3'b000, 1'b0);
    apply_check("rst_hold_101", 3'b101, 1'b1);

    // reset toggled mid-cycle with inputs stable
    #0;
    reset = 1'b0;
    #0.5;
    check("rst_deassert_101", bus.f, 1'b1);
    apply_check("rst_mid_110", 3'b110, 1'b1);
    #0;
    reset = 1'b1;
    #0.5;
    check("rst_assert_110", bus.f, 1'b1);
    apply(3'b000);
    reset = 1'b0;
    #0.5;
    check("rst_deassert_000", bus.f, 1'b0);

    // history independence: 000 after each nonzero pattern
    for (int i = 0; i < 7; i++) begin
      apply_check($sformatf("hist_pre_%0d", i), hist_pat[i], 1'b1);
      apply_check($sformatf("hist_000_after_%0d", i), 3'b000, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time guard
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/comb_bool_kmap1.md
COMB_BOOL_KMAP1 -- requirements
Module: comb_bool_kmap1

Interface
Parameters: none.
REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
REQ-002: clk  input  1  clock; no output depends on it.
REQ-003: reset  input  1  synchronous active-high reset; no output depends on it.
REQ-004: a  input  1  most-significant Boolean input (K-map row variable).
REQ-005: b  input  1  middle Boolean input (K-map column variable).
REQ-006: c  input  1  least-significant Boolean input (K-map column variable).
REQ-007: f  output  1  Boolean function result.

Function
REQ-008: f SHALL be a purely combinational function of {a,b,c}: no registers, no latches, no internal state.
REQ-009: f SHALL equal a OR b OR c, i.e. the K-map with a single 0 at minterm 000.
REQ-010: Truth table, index {a,b,c} -> f: 000->0, 001->1, 010->1, 011->1, 100->1, 101->1, 110->1, 111->1.
REQ-011: f SHALL settle within the same cycle as an input change, with zero cycles of latency.
REQ-012: f SHALL be valid well before the next rising clk edge when inputs are applied 1 time unit after an edge.
REQ-013: f SHALL NOT depend on clk, on reset, or on previous input values.
REQ-014: If any input is X or Z, f behaviour is unspecified; benches SHALL drive only 0 or 1.
REQ-015: The implementation SHALL be free of combinational loops and SHALL produce no inferred latches in synthesis.

Reset
REQ-016: Reset SHALL have no effect on f.
REQ-017: While reset=1, f SHALL still equal a|b|c.
REQ-018: There is no reset value; f is defined only by the current inputs.
REQ-019: A reset asserted mid-operation SHALL cause no glitch in f and no change to its value.

Verification
REQ-020: Exhaustive sweep: apply {a,b,c} = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle -> f = 0,1,1,1,1,1,1,1.
REQ-021: Single-input walk: from 000, set only c=1 -> f=1; set only b=1 -> f=1; set only a=1 -> f=1.
REQ-022: Return to zero: apply 111 then 000 in the next cycle -> f goes from 1 to 0 in the same cycle as the input change.
REQ-023: Reset independence: hold reset=1 and apply 000 then 101 -> f = 0 then 1.
REQ-024: Same-cycle response: change inputs 1 unit after a clk edge and sample f 8 units later -> f already matches the truth table.
REQ-025: Pattern-history independence: apply 000 after each of the other seven patterns -> f = 0 every time.
